input_conditioner: RTL and testbench
====================================

// Module: input_conditioner
// PURPOSE
//   Conditions raw board inputs (8 data switches, 3-bit test selector, confirm button) before the CPU's switch/MemoryOrIO path reads them.
//   Every input is 2-flop synchronised and debounced. A debounced confirm press captures a {switch, selector} snapshot.
//   The snapshot is held with a valid/ack handshake until the CPU reads it, so one press gives exactly one CPU read.
// PARAMETERS
//   SW_W    8       data switch width
//   IDX_W   3       test selector width
//   DB_CNT  200000  stable cycles required before a debounced output changes (>=2; ~10 ms at divided clock)
//   CNT_W   18      debounce counter width; 2**CNT_W > DB_CNT
// PORTS
//   clock       in   1      CPU clock (divided fpga_clk)
//   reset       in   1      asynchronous, active-high
//   sw_raw      in   SW_W   raw switch pins
//   idx_raw     in   IDX_W  raw test selector pins
//   btn_raw     in   1      raw confirm button, 1 = pressed
//   ack         in   1      CPU consumed snapshot (ioRead & SwitchCtrl), 1-cycle pulse
//   sw_stable   out  SW_W   debounced switches (live)
//   idx_stable  out  IDX_W  debounced selector (live)
//   btn_level   out  1      debounced button level
//   btn_press   out  1      1-cycle pulse on debounced button rising edge
//   snap_valid  out  1      snapshot held, not yet acked
//   snap_data   out  SW_W   captured sw_stable
//   snap_idx    out  IDX_W  captured idx_stable
//   overrun     out  1      sticky: press arrived while snap_valid=1
// BEHAVIOUR
//   - Reset (async, any time): all outputs, sync flops, candidates and counters go to 0. Counting restarts after release.
//   - Sync: s1<=raw, s2<=s1 per bit. s2 is the synced value.
//   - Debounce: three independent channels (sw vector, idx vector, btn), each with cand, cnt and stable registers. Per edge:
//       s2!=cand             : cand<=s2, cnt<=0
//       else cand!=stable    : if cnt==DB_CNT-1 {stable<=cand; cnt<=0} else cnt<=cnt+1
//       else                 : cnt<=0
//     Vector channels switch as a whole word. Any bit change restarts the count.
//   - Latency: raw held constant from sampling edge 1 -> stable updates at edge DB_CNT+3. Any bounce restarts the count.
//   - btn_press = registered (btn_level & ~btn_prev). It is high for the one cycle after edge DB_CNT+4. A release generates no pulse.
//   - Snapshot handshake, evaluated on the edge where btn_press goes high (rise):
//       rise & !snap_valid       : snap_data/snap_idx <= sw_stable/idx_stable; snap_valid<=1
//       rise & snap_valid & ack  : recapture; snap_valid stays 1; overrun unchanged
//       rise & snap_valid & !ack : snapshot unchanged; overrun<=1
//       ack & !rise              : snap_valid<=0, overrun<=0; snap_data/snap_idx keep their last value
//       ack while !snap_valid    : ignored
//   - snap_data and snap_idx change only on capture. They are stable whenever snap_valid=1.
//   - No wrap-around: cnt never exceeds DB_CNT-1.
// TESTING (bench uses DB_CNT=4)
//   1 Reset pulse mid-run, sw_raw=0xFF -> all outputs 0 immediately. sw_stable=0xFF 7 edges after release.
//   2 sw_raw 0x00->0xA5 held -> sw_stable stays 0x00 through edge 6 and is 0xA5 after edge 7. idx_stable is unaffected.
//   3 sw_raw alternates 0xA5/0x00 every 2 cycles for 12 cycles, then holds 0xA5 -> no sw_stable change while bouncing. 0xA5 appears 7 edges after the last change.
//   4 sw=0x3C, idx=5, btn held 10 cycles -> exactly one btn_press pulse; snap_valid=1, snap_data=0x3C, snap_idx=5. ack -> snap_valid=0 next cycle, data held.
//   5 Snapshot held (0x3C), sw=0x11, second press without ack -> overrun=1, snap_data stays 0x3C. ack -> snap_valid=0, overrun=0.
//   6 Snapshot held, sw=0x22, ack on the same edge as the press rise -> snap_valid stays 1, snap_data=0x22, overrun=0.

Source files
------------

// File: rtl/input_conditioner_if.sv
// Signal bundle between the raw board inputs and the CPU-side consumer of the input conditioner.
// Handshake: snap_valid holds a snapshot until a 1-cycle ack; ack with snap_valid low is ignored.
interface input_conditioner_if #(
  parameter int SW_W  = 8,
  parameter int IDX_W = 3
);
  logic [SW_W-1:0]  sw_raw;
  logic [IDX_W-1:0] idx_raw;
  logic             btn_raw;
  logic             ack;
  logic [SW_W-1:0]  sw_stable;
  logic [IDX_W-1:0] idx_stable;
  logic             btn_level;
  logic             btn_press;
  logic             snap_valid;
  logic [SW_W-1:0]  snap_data;
  logic [IDX_W-1:0] snap_idx;
  logic             overrun;
  logic             snap_state;

  modport slave (
    input  sw_raw, idx_raw, btn_raw, ack,
    output sw_stable, idx_stable, btn_level, btn_press,
           snap_valid, snap_data, snap_idx, overrun, snap_state
  );

  modport master (
    output sw_raw, idx_raw, btn_raw, ack,
    input  sw_stable, idx_stable, btn_level, btn_press,
           snap_valid, snap_data, snap_idx, overrun, snap_state
  );
endinterface

// File: rtl/input_conditioner.sv
// Synchronises and debounces switches, selector and confirm button, and holds one
// {switch, selector} snapshot per confirm press until the CPU acknowledges it.
module input_conditioner #(
  parameter int SW_W   = 8,
  parameter int IDX_W  = 3,
  parameter int DB_CNT = 200000,
  parameter int CNT_W  = 18
) (
  input logic                clock,
  input logic                reset,
  input_conditioner_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {SNAP_EMPTY = 1'b0, SNAP_HELD = 1'b1} snap_state_e;

  logic [SW_W-1:0]  sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [SW_W-1:0]  sw_cand_q, sw_cand_d, sw_stable_q, sw_stable_d;
  logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d;
  logic [IDX_W-1:0] idx_s1_q, idx_s1_d, idx_s2_q, idx_s2_d;
  logic [IDX_W-1:0] idx_cand_q, idx_cand_d, idx_stable_q, idx_stable_d;
  logic [CNT_W-1:0] idx_cnt_q, idx_cnt_d;
  logic             btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic             btn_cand_q, btn_cand_d, btn_stable_q, btn_stable_d;
  logic [CNT_W-1:0] btn_cnt_q, btn_cnt_d;
  logic             btn_prev_q, btn_prev_d, btn_press_q, btn_press_d;
  snap_state_e      snap_state_q, snap_state_d;
  logic [SW_W-1:0]  snap_data_q, snap_data_d;
  logic [IDX_W-1:0] snap_idx_q, snap_idx_d;
  logic             overrun_q, overrun_d;
  logic             rise;

  // Debounce: a candidate must stay unchanged for DB_CNT counted edges before it is promoted.
  always_comb begin
    sw_s1_d  = bus.sw_raw;
    sw_s2_d  = sw_s1_q;
    idx_s1_d = bus.idx_raw;
    idx_s2_d = idx_s1_q;
    btn_s1_d = bus.btn_raw;
    btn_s2_d = btn_s1_q;

    sw_cand_d   = sw_cand_q;
    sw_stable_d = sw_stable_q;
    sw_cnt_d    = '0;
    if (sw_s2_q != sw_cand_q) begin
      sw_cand_d = sw_s2_q;
    end else if (sw_cand_q != sw_stable_q) begin
      if (sw_cnt_q == CNT_LAST) sw_stable_d = sw_cand_q;
      else                      sw_cnt_d    = sw_cnt_q + CNT_ONE;
    end

    idx_cand_d   = idx_cand_q;
    idx_stable_d = idx_stable_q;
    idx_cnt_d    = '0;
    if (idx_s2_q != idx_cand_q) begin
      idx_cand_d = idx_s2_q;
    end else if (idx_cand_q != idx_stable_q) begin
      if (idx_cnt_q == CNT_LAST) idx_stable_d = idx_cand_q;
      else                       idx_cnt_d    = idx_cnt_q + CNT_ONE;
    end

    btn_cand_d   = btn_cand_q;
    btn_stable_d = btn_stable_q;
    btn_cnt_d    = '0;
    if (btn_s2_q != btn_cand_q) begin
      btn_cand_d = btn_s2_q;
    end else if (btn_cand_q != btn_stable_q) begin
      if (btn_cnt_q == CNT_LAST) btn_stable_d = btn_cand_q;
      else                       btn_cnt_d    = btn_cnt_q + CNT_ONE;
    end
  end

  // Snapshot holder; the capture happens on the same edge that raises btn_press.
  always_comb begin
    rise         = btn_stable_q & ~btn_prev_q;
    btn_prev_d   = btn_stable_q;
    btn_press_d  = rise;
    snap_state_d = snap_state_q;
    snap_data_d  = snap_data_q;
    snap_idx_d   = snap_idx_q;
    overrun_d    = overrun_q;
    case (snap_state_q)
      SNAP_EMPTY: begin
        if (rise) begin
          snap_data_d  = sw_stable_q;
          snap_idx_d   = idx_stable_q;
          snap_state_d = SNAP_HELD;
        end
      end
      SNAP_HELD: begin
        if (rise) begin
          if (bus.ack) begin
            snap_data_d = sw_stable_q;
            snap_idx_d  = idx_stable_q;
          end else begin
            overrun_d = 1'b1;
          end
        end else if (bus.ack) begin
          snap_state_d = SNAP_EMPTY;
          overrun_d    = 1'b0;
        end
      end
      default: snap_state_d = SNAP_EMPTY;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_s1_q      <= '0;
      sw_s2_q      <= '0;
      sw_cand_q    <= '0;
      sw_stable_q  <= '0;
      sw_cnt_q     <= '0;
      idx_s1_q     <= '0;
      idx_s2_q     <= '0;
      idx_cand_q   <= '0;
      idx_stable_q <= '0;
      idx_cnt_q    <= '0;
      btn_s1_q     <= 1'b0;
      btn_s2_q     <= 1'b0;
      btn_cand_q   <= 1'b0;
      btn_stable_q <= 1'b0;
      btn_cnt_q    <= '0;
      btn_prev_q   <= 1'b0;
      btn_press_q  <= 1'b0;
      snap_state_q <= SNAP_EMPTY;
      snap_data_q  <= '0;
      snap_idx_q   <= '0;
      overrun_q    <= 1'b0;
    end else begin
      sw_s1_q      <= sw_s1_d;
      sw_s2_q      <= sw_s2_d;
      sw_cand_q    <= sw_cand_d;
      sw_stable_q  <= sw_stable_d;
      sw_cnt_q     <= sw_cnt_d;
      idx_s1_q     <= idx_s1_d;
      idx_s2_q     <= idx_s2_d;
      idx_cand_q   <= idx_cand_d;
      idx_stable_q <= idx_stable_d;
      idx_cnt_q    <= idx_cnt_d;
      btn_s1_q     <= btn_s1_d;
      btn_s2_q     <= btn_s2_d;
      btn_cand_q   <= btn_cand_d;
      btn_stable_q <= btn_stable_d;
      btn_cnt_q    <= btn_cnt_d;
      btn_prev_q   <= btn_prev_d;
      btn_press_q  <= btn_press_d;
      snap_state_q <= snap_state_d;
      snap_data_q  <= snap_data_d;
      snap_idx_q   <= snap_idx_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.sw_stable  = sw_stable_q;
  assign bus.idx_stable = idx_stable_q;
  assign bus.btn_level  = btn_stable_q;
  assign bus.btn_press  = btn_press_q;
  assign bus.snap_valid = (snap_state_q == SNAP_HELD);
  assign bus.snap_data  = snap_data_q;
  assign bus.snap_idx   = snap_idx_q;
  assign bus.overrun    = overrun_q;
  assign bus.snap_state = snap_state_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with a short debounce window; each press pushes the snapshot
// it should leave behind, and the btn_press monitor pops and compares it.
module tb_input_conditioner;
  localparam int SW_W   = 8;
  localparam int IDX_W  = 3;
  localparam int DB_CNT = 4;
  localparam int CNT_W  = 3;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  logic [SW_W+IDX_W-1:0] exp_q[$];

  input_conditioner_if #(.SW_W(SW_W), .IDX_W(IDX_W)) bus ();

  input_conditioner #(.SW_W(SW_W), .IDX_W(IDX_W), .DB_CNT(DB_CNT), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic settle(input logic [SW_W-1:0] sw, input logic [IDX_W-1:0] idx);
    bus.sw_raw  = sw;
    bus.idx_raw = idx;
    cyc(DB_CNT + 4);
  endtask

  // Button held past the debounce window, then released and allowed to settle back.
  task automatic press(input logic [SW_W-1:0] exp_sw, input logic [IDX_W-1:0] exp_idx);
    exp_q.push_back({exp_idx, exp_sw});
    bus.btn_raw = 1'b1;
    cyc(10);
    bus.btn_raw = 1'b0;
    cyc(DB_CNT + 5);
  endtask

  task automatic pulse_ack();
    bus.ack = 1'b1;
    cyc(1);
    bus.ack = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    if (!reset && bus.btn_press) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL press_unexpected: btn_press=1 with no press pending at %0t", $time);
      end else begin
        logic [SW_W+IDX_W-1:0] exp;
        exp = exp_q.pop_front();
        if ({bus.snap_idx, bus.snap_data} !== exp || bus.snap_valid !== 1'b1) begin
          errors++;
          $display("FAIL snapshot: got valid=%b idx=%0d data=%h expected valid=1 idx=%0d data=%h",
                   bus.snap_valid, bus.snap_idx, bus.snap_data, exp[SW_W+IDX_W-1:SW_W], exp[SW_W-1:0]);
        end
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [2*SW_W+2*IDX_W+5-1:0] outs;
    reset = 1'b1;
    bus.sw_raw = '0; bus.idx_raw = '0; bus.btn_raw = 1'b0; bus.ack = 1'b0;
    cyc(3);
    reset = 1'b0;
    outs = {bus.sw_stable, bus.idx_stable, bus.btn_level, bus.btn_press,
            bus.snap_valid, bus.snap_data, bus.snap_idx, bus.overrun};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0", outs);
    end
    bus.sw_raw = 8'hFF;
    cyc(10);
    checks++;
    if (bus.sw_stable !== 8'hFF) begin
      errors++;
      $display("FAIL pre_reset_sw: got %h expected ff", bus.sw_stable);
    end
    #3;
    reset = 1'b1;
    #1;
    outs = {bus.sw_stable, bus.idx_stable, bus.btn_level, bus.btn_press,
            bus.snap_valid, bus.snap_data, bus.snap_idx, bus.overrun};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0", outs);
    end
    cyc(1);
    reset = 1'b0;
    cyc(DB_CNT + 2);
    checks++;
    if (bus.sw_stable !== 8'h00) begin
      errors++;
      $display("FAIL reset_release_early: got %h expected 00", bus.sw_stable);
    end
    cyc(1);
    checks++;
    if (bus.sw_stable !== 8'hFF) begin
      errors++;
      $display("FAIL reset_release_latency: got %h expected ff", bus.sw_stable);
    end
  endtask

  task automatic test_latency();
    settle(8'h00, 3'd0);
    bus.sw_raw = 8'hA5;
    for (int e = 1; e <= DB_CNT + 3; e++) begin
      logic [SW_W-1:0] exp;
      cyc(1);
      exp = (e < DB_CNT + 3) ? 8'h00 : 8'hA5;
      checks++;
      if (bus.sw_stable !== exp || bus.idx_stable !== 3'd0) begin
        errors++;
        $display("FAIL latency_edge%0d: got sw=%h idx=%0d expected sw=%h idx=0",
                 e, bus.sw_stable, bus.idx_stable, exp);
      end
    end
  endtask

  task automatic test_bounce();
    settle(8'h00, 3'd0);
    for (int i = 0; i < 6; i++) begin
      bus.sw_raw = (i % 2 == 0) ? 8'hA5 : 8'h00;
      cyc(2);
      checks++;
      if (bus.sw_stable !== 8'h00) begin
        errors++;
        $display("FAIL bounce_phase%0d: got %h expected 00", i, bus.sw_stable);
      end
    end
    bus.sw_raw = 8'hA5;
    cyc(DB_CNT + 2);
    checks++;
    if (bus.sw_stable !== 8'h00) begin
      errors++;
      $display("FAIL bounce_hold_early: got %h expected 00", bus.sw_stable);
    end
    cyc(1);
    checks++;
    if (bus.sw_stable !== 8'hA5) begin
      errors++;
      $display("FAIL bounce_hold_final: got %h expected a5", bus.sw_stable);
    end
  endtask

  task automatic test_snapshot();
    settle(8'h3C, 3'd5);
    press(8'h3C, 3'd5);
    checks++;
    if (bus.snap_valid !== 1'b1 || bus.snap_data !== 8'h3C || bus.snap_idx !== 3'd5) begin
      errors++;
      $display("FAIL snap_hold: got valid=%b data=%h idx=%0d expected valid=1 data=3c idx=5",
               bus.snap_valid, bus.snap_data, bus.snap_idx);
    end
    pulse_ack();
    checks++;
    if (bus.snap_valid !== 1'b0 || bus.snap_data !== 8'h3C || bus.snap_idx !== 3'd5) begin
      errors++;
      $display("FAIL snap_ack: got valid=%b data=%h idx=%0d expected valid=0 data=3c idx=5",
               bus.snap_valid, bus.snap_data, bus.snap_idx);
    end
    pulse_ack();
    checks++;
    if (bus.snap_valid !== 1'b0 || bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL idle_ack: got valid=%b overrun=%b expected valid=0 overrun=0",
               bus.snap_valid, bus.overrun);
    end
  endtask

  task automatic test_overrun();
    press(8'h3C, 3'd5);
    settle(8'h11, 3'd5);
    press(8'h3C, 3'd5);
    checks++;
    if (bus.overrun !== 1'b1 || bus.snap_valid !== 1'b1 || bus.snap_data !== 8'h3C) begin
      errors++;
      $display("FAIL overrun_set: got overrun=%b valid=%b data=%h expected overrun=1 valid=1 data=3c",
               bus.overrun, bus.snap_valid, bus.snap_data);
    end
    pulse_ack();
    checks++;
    if (bus.overrun !== 1'b0 || bus.snap_valid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: got overrun=%b valid=%b expected overrun=0 valid=0",
               bus.overrun, bus.snap_valid);
    end
  endtask

  task automatic test_back_to_back();
    press(8'h11, 3'd5);
    settle(8'h22, 3'd5);
    exp_q.push_back({3'd5, 8'h22});
    bus.btn_raw = 1'b1;
    cyc(DB_CNT + 3);
    bus.ack = 1'b1;
    cyc(1);
    bus.ack = 1'b0;
    checks++;
    if (bus.snap_valid !== 1'b1 || bus.snap_data !== 8'h22 || bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL same_edge_ack: got valid=%b data=%h overrun=%b expected valid=1 data=22 overrun=0",
               bus.snap_valid, bus.snap_data, bus.overrun);
    end
    cyc(3);
    bus.btn_raw = 1'b0;
    cyc(DB_CNT + 5);
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_latency();
    test_bounce();
    test_snapshot();
    test_overrun();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL press_missing: got %0d presses outstanding expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
